// File: rtl/issue_multi_fifo.sv
// issue_multi_fifo: multi-lane in-order issue buffer with first-word-fall-through dequeue lanes.
// Optional partial squash of younger entries is built when ISSUE_MFIFO_SQUASH_EN is defined.
module issue_multi_fifo #(
    parameter int DEPTH      = 16,
    parameter int DATA_WIDTH = 32,
    parameter int ENQ_WIDTH  = 2,
    parameter int DEQ_WIDTH  = 2,
    localparam int CNT_W     = $clog2(DEPTH) + 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            flush,
    input  logic [ENQ_WIDTH-1:0]            enq_valid,
    input  logic [ENQ_WIDTH*DATA_WIDTH-1:0] enq_data,
    output logic [ENQ_WIDTH-1:0]            enq_ready,
    output logic [DEQ_WIDTH-1:0]            deq_valid,
    output logic [DEQ_WIDTH*DATA_WIDTH-1:0] deq_data,
    input  logic [DEQ_WIDTH-1:0]            deq_ready,
    input  logic                            squash_en,
    input  logic [CNT_W-1:0]                squash_keep,
    output logic [CNT_W-1:0]                count,
    output logic                            full,
    output logic                            empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]      rd_ptr_r, wr_ptr_r, rd_ptr_nxt_s, wr_ptr_nxt_s, sq_wr_ptr_s;
    logic [CNT_W-1:0]      count_r, count_nxt_s, enq_n_s, deq_m_s, sq_count_s;
    logic                  full_r, empty_r;
    logic                  enq_run_s, deq_run_s, squash_act_s, wr_en_s;

`ifdef ISSUE_MFIFO_SQUASH_EN
    logic [CNT_W-1:0] keep_s;
    assign squash_act_s = squash_en & ~flush;
    assign keep_s       = (squash_keep < count_r) ? squash_keep : count_r;
    assign sq_count_s   = (keep_s > deq_m_s) ? (keep_s - deq_m_s) : '0;
    // When pops outrun the retained set, park wr_ptr on the new rd_ptr so the queue stays coherent.
    assign sq_wr_ptr_s  = rd_ptr_r + ((keep_s > deq_m_s) ? keep_s[PTR_W-1:0] : deq_m_s[PTR_W-1:0]);
`else
    logic unused_squash_s;
    assign unused_squash_s = ^{squash_en, squash_keep};
    assign squash_act_s    = 1'b0;
    assign sq_count_s      = '0;
    assign sq_wr_ptr_s     = '0;
`endif

    assign wr_en_s = ~rst & ~flush & ~squash_act_s;
    assign count   = count_r;
    assign full    = full_r;
    assign empty   = empty_r;

    // Lane handshakes derived only from the registered occupancy.
    always_comb begin
        enq_ready = '0;
        deq_valid = '0;
        for (int i = 0; i < ENQ_WIDTH; i++) begin
            enq_ready[i] = (DEPTH_C - count_r) > CNT_W'(i);
        end
        for (int i = 0; i < DEQ_WIDTH; i++) begin
            deq_valid[i] = count_r > CNT_W'(i);
        end
    end

    // Accepted enqueue / pop counts: contiguous prefix from lane 0 only.
    always_comb begin
        enq_n_s   = '0;
        deq_m_s   = '0;
        enq_run_s = 1'b1;
        deq_run_s = 1'b1;
        for (int i = 0; i < ENQ_WIDTH; i++) begin
            if (enq_run_s && enq_valid[i] && enq_ready[i]) begin
                enq_n_s = enq_n_s + CNT_W'(1);
            end else begin
                enq_run_s = 1'b0;
            end
        end
        for (int i = 0; i < DEQ_WIDTH; i++) begin
            if (deq_run_s && deq_valid[i] && deq_ready[i]) begin
                deq_m_s = deq_m_s + CNT_W'(1);
            end else begin
                deq_run_s = 1'b0;
            end
        end
    end

    // Next pointer/occupancy with flush over squash over normal traffic.
    always_comb begin
        rd_ptr_nxt_s = rd_ptr_r + deq_m_s[PTR_W-1:0];
        wr_ptr_nxt_s = wr_ptr_r + enq_n_s[PTR_W-1:0];
        count_nxt_s  = count_r + enq_n_s - deq_m_s;
        if (flush) begin
            rd_ptr_nxt_s = '0;
            wr_ptr_nxt_s = '0;
            count_nxt_s  = '0;
        end else if (squash_act_s) begin
            wr_ptr_nxt_s = sq_wr_ptr_s;
            count_nxt_s  = sq_count_s;
        end else begin
            count_nxt_s  = count_r + enq_n_s - deq_m_s;
        end
    end

    // Payload storage; never reset, slots outside [rd_ptr, wr_ptr) are don't-care.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            for (int k = 0; k < ENQ_WIDTH; k++) begin
                if (CNT_W'(k) < enq_n_s) begin
                    mem_r[wr_ptr_r + PTR_W'(k)] <= enq_data[k*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    // Pointer, occupancy and status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            rd_ptr_r <= rd_ptr_nxt_s;
            wr_ptr_r <= wr_ptr_nxt_s;
            count_r  <= count_nxt_s;
            full_r   <= (count_nxt_s == DEPTH_C);
            empty_r  <= (count_nxt_s == '0);
        end
    end

    // Oldest entries presented first-word-fall-through, wrapping modulo DEPTH.
    for (genvar i = 0; i < DEQ_WIDTH; i++) begin : g_deq
        assign deq_data[i*DATA_WIDTH +: DATA_WIDTH] = mem_r[rd_ptr_r + PTR_W'(i)];
    end
endmodule

// File: tb/tb_issue_multi_fifo.sv
// Directed self-checking bench for issue_multi_fifo (DEPTH=16, 2 enqueue / 2 dequeue lanes).
module tb_issue_multi_fifo;
    localparam int DW    = 32;
    localparam int CNT_W = 5;

    logic              clk = 1'b0;
    logic              rst, flush, squash_en;
    logic [1:0]        enq_valid, enq_ready, deq_valid, deq_ready;
    logic [2*DW-1:0]   enq_data, deq_data;
    logic [CNT_W-1:0]  squash_keep, count;
    logic              full, empty;
    int                n_cmp = 0;
    int                n_err = 0;

    issue_multi_fifo #(.DEPTH(16), .DATA_WIDTH(DW), .ENQ_WIDTH(2), .DEQ_WIDTH(2)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .enq_valid(enq_valid), .enq_data(enq_data), .enq_ready(enq_ready),
        .deq_valid(deq_valid), .deq_data(deq_data), .deq_ready(deq_ready),
        .squash_en(squash_en), .squash_keep(squash_keep),
        .count(count), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
        flush     = 1'b0;
        enq_valid = 2'b00;
        deq_ready = 2'b00;
        squash_en = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic enq2(input logic [31:0] a, input logic [31:0] b);
        enq_valid = 2'b11;
        enq_data  = {b, a};
        cyc();
    endtask

    task automatic pop2();
        deq_ready = 2'b11;
        cyc();
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; squash_en = 1'b0; squash_keep = '0;
        enq_valid = 2'b00; deq_ready = 2'b00; enq_data = '0;
        cyc(); cyc();
        rst = 1'b0;
        chk("rst_count", count, 64'd0);
        chk("rst_empty", empty, 64'd1);
        chk("rst_full", full, 64'd0);
        chk("rst_deq_valid", deq_valid, 64'd0);
        chk("rst_enq_ready", enq_ready, 64'd3);

        // two lanes in, visible next cycle
        enq2(32'hAAAA_0001, 32'hBBBB_0002);
        chk("t1_deq_valid", deq_valid, 64'd3);
        chk("t1_deq_data", deq_data, 64'hBBBB_0002_AAAA_0001);
        chk("t1_count", count, 64'd2);
        pop2();
        chk("t1_empty", empty, 64'd1);

        // fill to DEPTH
        for (int k = 0; k < 8; k++) enq2(32'h100 + 2*k, 32'h101 + 2*k);
        chk("t2_count", count, 64'd16);
        chk("t2_full", full, 64'd1);
        chk("t2_enq_ready", enq_ready, 64'd0);
        chk("t2_deq_data", deq_data, {32'h101, 32'h100});
        enq2(32'hDEAD_0000, 32'hDEAD_0001);
        chk("t2_ovf_count", count, 64'd16);
        chk("t2_ovf_data", deq_data, {32'h101, 32'h100});

        // partial acceptance at count 15
        deq_ready = 2'b01; cyc();
        chk("t3_count15", count, 64'd15);
        chk("t3_enq_ready", enq_ready, 64'd1);
        chk("t3_full", full, 64'd0);
        enq2(32'h1F0, 32'h1F1);
        chk("t3_count16", count, 64'd16);
        deq_ready = 2'b01; cyc();
        chk("t3_deq_data", deq_data, {32'h103, 32'h102});
        deq_ready = 2'b01; enq2(32'h1F2, 32'h1F3);
        chk("t3_count_same", count, 64'd15);
        chk("t3_deq_data2", deq_data, {32'h104, 32'h103});
        flush = 1'b1; cyc();
        chk("t3_flush_empty", empty, 64'd1);

        // wrap across DEPTH-1 -> 0
        for (int k = 0; k < 7; k++) enq2(32'h200 + 2*k, 32'h201 + 2*k);
        chk("t4_count14", count, 64'd14);
        for (int j = 0; j < 7; j++) begin
            chk("t4_drain_data", deq_data, {32'h201 + 2*j, 32'h200 + 2*j});
            pop2();
        end
        chk("t4_drained", count, 64'd0);
        enq2(32'h300, 32'h301);
        enq2(32'h302, 32'h303);
        chk("t4_wrap_count", count, 64'd4);
        chk("t4_wrap_data0", deq_data, {32'h301, 32'h300});
        pop2();
        chk("t4_wrap_data1", deq_data, {32'h303, 32'h302});
        pop2();
        chk("t4_wrap_empty", empty, 64'd1);

        // flush beats concurrent enq/deq
        for (int k = 0; k < 3; k++) enq2(32'h400 + 2*k, 32'h401 + 2*k);
        chk("t5_count6", count, 64'd6);
        flush = 1'b1; deq_ready = 2'b11; enq2(32'hBAD0, 32'hBAD1);
        chk("t5_count", count, 64'd0);
        chk("t5_empty", empty, 64'd1);
        chk("t5_deq_valid", deq_valid, 64'd0);
        enq_valid = 2'b01; enq_data = {32'h0, 32'h500}; cyc();
        chk("t5_post_valid", deq_valid, 64'd1);
        chk("t5_post_data", deq_data[31:0], 64'h500);
        deq_ready = 2'b01; cyc();
        chk("t5_post_empty", empty, 64'd1);

        // squash (ignored without the macro)
        for (int k = 0; k < 4; k++) enq2(32'h600 + 2*k, 32'h601 + 2*k);
        chk("t6_count8", count, 64'd8);
        squash_en = 1'b1; squash_keep = 5'd3; deq_ready = 2'b01; cyc();
`ifdef ISSUE_MFIFO_SQUASH_EN
        chk("t6_sq_count", count, 64'd2);
`else
        chk("t6_sq_count", count, 64'd7);
`endif
        chk("t6_sq_data", deq_data, {32'h602, 32'h601});
`ifdef ISSUE_MFIFO_SQUASH_EN
        enq2(32'h700, 32'h701);
        chk("t6_sq_refill", count, 64'd4);
        pop2();
        chk("t6_sq_order", deq_data, {32'h701, 32'h700});
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/issue_multi_fifo.md
# issue_multi_fifo

Multi-lane in-order issue buffer for the superscalar issue stage. It sits between dispatch and functional-unit issue and replaces the single-lane issue FIFO. It accepts up to ENQ_WIDTH reservation-station entries per cycle and presents the oldest DEQ_WIDTH entries with first-word-fall-through. It supports a full pipeline flush and, optionally, a partial squash that discards younger entries on branch mispredict.

## Interface
- DEPTH, 16: entry count; power of two, ≥ max(ENQ_WIDTH, DEQ_WIDTH)
- DATA_WIDTH, $bits(RS_ENTRY_t): payload bits per entry
- ENQ_WIDTH, 2: enqueue lanes per cycle, 1..4
- DEQ_WIDTH, 2: dequeue lanes per cycle, 1..4
- CNT_W (localparam), $clog2(DEPTH)+1
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  drop all entries
- enq_valid  in  ENQ_WIDTH  per-lane write request
- enq_data  in  ENQ_WIDTH×DATA_WIDTH  lane i payload at [i*DATA_WIDTH +: DATA_WIDTH]
- enq_ready  out  ENQ_WIDTH  lane i may be accepted
- deq_valid  out  DEQ_WIDTH  lane i holds the i-th oldest entry
- deq_data  out  DEQ_WIDTH×DATA_WIDTH  payload of the i-th oldest entry
- deq_ready  in  DEQ_WIDTH  consumer pops lane i
- squash_en  in  1  partial squash (only with ISSUE_MFIFO_SQUASH_EN)
- squash_keep  in  CNT_W  number of oldest entries to retain
- count  out  CNT_W  occupied entries
- full  out  1  count == DEPTH
- empty  out  1  count == 0

## Operation
- State: mem[DEPTH], rd_ptr and wr_ptr ($clog2(DEPTH) bits, natural wrap), count.
- enq_ready[i] = (DEPTH − count) > i, computed from registered count only.
- Accepted enqueues = longest contiguous prefix from lane 0 with enq_valid & enq_ready. Lanes after the first gap are ignored (protocol violation; no write).
- Accepted lane k of n writes mem[wr_ptr+k]. Then wr_ptr += n.
- deq_valid[i] = count > i. deq_data[i] = mem[rd_ptr+i] (mod DEPTH).
- Popped = longest contiguous prefix with deq_valid & deq_ready, giving m. Then rd_ptr += m.
- count_next = count + n − m. Overflow and underflow are structurally impossible.
- Slots freed by pops in a cycle are not reusable by enqueues in that same cycle.
- Priority: rst > flush > squash > normal enq/deq.
- flush: rd_ptr, wr_ptr and count go to 0. Enq and deq in that cycle are discarded. mem is not cleared.
- No combinational path from any input to any output.

## Timing
- Reset: count=0, rd_ptr=wr_ptr=0, empty=1, full=0, deq_valid=0, enq_ready=all-1.
- deq_data is X/don't-care while its deq_valid is 0.
- Latency: an entry enqueued at edge N appears on deq_valid/deq_data after edge N (visible in cycle N+1). There is no same-cycle bypass.
- Throughput: ENQ_WIDTH in and DEQ_WIDTH out per cycle when not full or empty.
- Pointer wrap: lanes straddling DEPTH−1→0 are written and read correctly.
- Reset or flush asserted mid-burst: effective at that edge. The next cycle shows empty=1.
- full/empty/count update on the same edge as the pointers.

## Configuration
- ISSUE_MFIFO_SQUASH_EN defined:
  - When squash_en=1 and flush=0, that cycle's enqueues are discarded.
  - Pops still apply: count_next = min(count, squash_keep) − m, clamped at 0.
  - wr_ptr_next = rd_ptr + min(count, squash_keep), so younger entries are dropped.
- ISSUE_MFIFO_SQUASH_EN undefined:
  - squash_en and squash_keep ports still exist but are ignored.
  - No squash logic is synthesised.

## Test plan
- Reset, then enq_valid=2'b11 with A, B. Next cycle: deq_valid=2'b11, deq_data={B, A}, count=2.
- DEPTH=16, enqueue 2/cycle for 8 cycles with deq_ready=0. Result: count=16, full=1, enq_ready=2'b00. A 9th enqueue is not written.
- count=15, enq_valid=2'b11: enq_ready=2'b01, only lane 0 accepted, count=16. With deq_ready=2'b01 in the same cycle, count stays 15+1−1=15.
- Fill to 14, pop 14, then enqueue 4 entries so they wrap indices 14,15,0,1. Dequeue order and data are preserved.
- flush=1 together with enq_valid=2'b11 and deq_ready=2'b11 at count=6. Next cycle: count=0, empty=1, deq_valid=0.
- With ISSUE_MFIFO_SQUASH_EN: count=8, squash_en=1, squash_keep=3, deq_ready=2'b01. Next cycle: count=2, and the two oldest survivors are unchanged. Without the macro, the same stimulus gives count=7.
